// File: rtl/path_search_ctrl_if.sv
// Bundle between the search controller, the mission requester, the adjacency
// ROM and the path consumer. The controller takes the slave side.
interface path_search_ctrl_if #(
  parameter int NODE_W = 5,
  parameter int DIST_W = 7
);
  logic              start;
  logic [NODE_W-1:0] src;
  logic [NODE_W-1:0] dst;
  logic [NODE_W-1:0] node_addr;
  logic [NODE_W+1:0] nb0;
  logic [NODE_W+1:0] nb1;
  logic [NODE_W+1:0] nb2;
  logic [NODE_W+1:0] nb3;
  logic              busy;
  logic              done;
  logic              err;
  logic [NODE_W-1:0] path_len;
  logic [DIST_W-1:0] total_cost;
  logic [NODE_W-1:0] path_node;
  logic              path_valid;
  logic              path_ready;
  logic              path_last;

  modport master (
    output start, src, dst, nb0, nb1, nb2, nb3, path_ready,
    input  node_addr, busy, done, err, path_len, total_cost,
           path_node, path_valid, path_last
  );

  modport slave (
    input  start, src, dst, nb0, nb1, nb2, nb3, path_ready,
    output node_addr, busy, done, err, path_len, total_cost,
           path_node, path_valid, path_last
  );
endinterface

// File: rtl/path_search_ctrl.sv
// Dijkstra shortest-path sequencer over the adjacency ROM. Scans for the
// closest unvisited node, relaxes its four ROM neighbours, then walks the
// predecessor chain back from dst into a LIFO and streams src..dst out.
module path_search_ctrl #(
  parameter int NUM_NODES = 26,
  parameter int NODE_W    = 5,
  parameter int DIST_W    = 7
) (
  input logic              clk,
  input logic              rst_n,
  path_search_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_SELECT    = 3'd2;
  localparam logic [2:0] S_EXPAND    = 3'd3;
  localparam logic [2:0] S_BACKTRACK = 3'd4;
  localparam logic [2:0] S_STREAM    = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam logic [DIST_W-1:0] INF    = {DIST_W{1'b1}};
  localparam logic [NODE_W-1:0] N_CNT  = NODE_W'(NUM_NODES);
  localparam logic [NODE_W-1:0] N_LAST = NODE_W'(NUM_NODES - 1);
  localparam logic [NODE_W-1:0] ONE    = NODE_W'(1);

  logic [2:0]        r_state;
  logic [NODE_W-1:0] r_src;
  logic [NODE_W-1:0] r_dst;
  logic [NODE_W-1:0] r_addr;
  logic [NODE_W-1:0] r_idx;
  logic [NODE_W-1:0] r_best_node;
  logic [DIST_W-1:0] r_best_dist;
  logic [NODE_W-1:0] r_u;
  logic [1:0]        r_slot;
  logic [NODE_W-1:0] r_bt_node;
  logic [NODE_W-1:0] r_sp;
  logic [NODE_W-1:0] r_len;
  logic [DIST_W-1:0] r_cost;
  logic [NODE_W-1:0] r_node;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic              r_err;

  logic [DIST_W-1:0]    r_dist [NUM_NODES];
  logic [NODE_W-1:0]    r_prev [NUM_NODES];
  logic [NUM_NODES-1:0] r_visited;
  logic [NODE_W-1:0]    r_lifo [NUM_NODES];

  logic              w_start_ok;
  logic              w_req_bad;
  logic              w_take;
  logic [NODE_W-1:0] w_sel_node;
  logic [DIST_W-1:0] w_sel_dist;
  logic              w_sel_expand;
  logic [NODE_W+1:0] w_nb;
  logic [NODE_W-1:0] w_v;
  logic [1:0]        w_cost;
  logic              w_edge;
  logic [NODE_W-1:0] w_v_idx;
  logic [DIST_W-1:0] w_nd;
  logic              w_relax;

  // A start arriving while the done pulse is still visible is not a new request.
  assign w_start_ok = bus.start && (r_state == S_IDLE) && !r_done;
  assign w_req_bad  = (bus.src >= N_CNT) || (bus.dst >= N_CNT);

  // Running minimum of the scan; strict compare keeps the lowest index on ties.
  assign w_take       = !r_visited[r_idx] && (r_dist[r_idx] < r_best_dist);
  assign w_sel_node   = w_take ? r_idx : r_best_node;
  assign w_sel_dist   = w_take ? r_dist[r_idx] : r_best_dist;
  assign w_sel_expand = (r_state == S_SELECT) && (r_idx == N_LAST) &&
                        (w_sel_dist != INF) && (w_sel_node != r_dst);

  // Select the ROM slot being relaxed this cycle.
  always_comb begin
    w_nb = bus.nb0;
    case (r_slot)
      2'd0:    w_nb = bus.nb0;
      2'd1:    w_nb = bus.nb1;
      2'd2:    w_nb = bus.nb2;
      default: w_nb = bus.nb3;
    endcase
  end

  // Sentinel ids are clamped to index 0 so the tables are never read out of range.
  assign w_v     = w_nb[NODE_W-1:0];
  assign w_cost  = w_nb[NODE_W+1:NODE_W];
  assign w_edge  = (w_v < N_CNT);
  assign w_v_idx = w_edge ? w_v : '0;
  assign w_nd    = r_dist[r_u] + {{(DIST_W-2){1'b0}}, w_cost};
  assign w_relax = w_edge && !r_visited[w_v_idx] && (w_nd < r_dist[w_v_idx]);

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.node_addr  = r_addr;
  assign bus.path_len   = r_len;
  assign bus.total_cost = r_cost;
  assign bus.path_node  = r_node;
  assign bus.path_valid = r_valid;
  assign bus.path_last  = r_last;

  // Sequencer: request capture, scan, expand, backtrack and stream control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_best_node <= '0;
      r_best_dist <= INF;
      r_u         <= '0;
      r_slot      <= '0;
      r_bt_node   <= '0;
      r_sp        <= '0;
      r_len       <= '0;
      r_cost      <= '0;
      r_node      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_err   <= 1'b0;
            r_src   <= bus.src;
            r_dst   <= bus.dst;
            r_state <= w_req_bad ? S_ERR : S_INIT;
          end
        end
        S_INIT: begin
          r_idx       <= '0;
          r_best_dist <= INF;
          r_best_node <= '0;
          r_state     <= S_SELECT;
        end
        S_SELECT: begin
          if (r_idx == N_LAST) begin
            r_idx       <= '0;
            r_best_dist <= INF;
            r_best_node <= '0;
            if (w_sel_dist == INF) begin
              r_state <= S_ERR;
            end else if (w_sel_node == r_dst) begin
              r_bt_node <= r_dst;
              r_sp      <= '0;
              r_len     <= '0;
              r_cost    <= w_sel_dist;
              r_state   <= S_BACKTRACK;
            end else begin
              r_u     <= w_sel_node;
              r_addr  <= w_sel_node;
              r_slot  <= '0;
              r_state <= S_EXPAND;
            end
          end else begin
            r_idx       <= r_idx + ONE;
            r_best_dist <= w_sel_dist;
            r_best_node <= w_sel_node;
          end
        end
        S_EXPAND: begin
          r_slot <= r_slot + 2'd1;
          if (r_slot == 2'd3) begin
            r_state <= S_SELECT;
          end
        end
        S_BACKTRACK: begin
          // A chain longer than the node count can only come from a corrupt table.
          if (r_sp == N_CNT) begin
            r_state <= S_ERR;
          end else begin
            r_sp  <= r_sp + ONE;
            r_len <= r_len + ONE;
            if (r_bt_node == r_src) begin
              r_state <= S_STREAM;
            end else begin
              r_bt_node <= r_prev[r_bt_node];
            end
          end
        end
        S_STREAM: begin
          if (!r_valid || bus.path_ready) begin
            if (r_sp != '0) begin
              r_node  <= r_lifo[r_sp - ONE];
              r_valid <= 1'b1;
              r_last  <= (r_sp == ONE);
              r_sp    <= r_sp - ONE;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-node distance, predecessor and visited tables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_dist[i] <= INF;
        r_prev[i] <= '0;
      end
      r_visited <= '0;
    end else if (r_state == S_INIT) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_dist[i] <= (NODE_W'(i) == r_src) ? '0 : INF;
      end
      r_visited <= '0;
    end else begin
      if (w_sel_expand) begin
        r_visited[w_sel_node] <= 1'b1;
      end
      if ((r_state == S_EXPAND) && w_relax) begin
        r_dist[w_v_idx] <= w_nd;
        r_prev[w_v_idx] <= r_u;
      end
    end
  end

  // Path LIFO filled dst-first during backtrack so src pops out first.
  always_ff @(posedge clk) begin
    if ((r_state == S_BACKTRACK) && (r_sp != N_CNT)) begin
      r_lifo[r_sp] <= r_bt_node;
    end
  end
endmodule

// File: doc/path_search_ctrl.md
Name: path_search_ctrl

Overview:
- Dijkstra shortest-path sequencer for the 26-node map adjacency ROM.
- Drives the ROM address, reads the four neighbour entries, keeps per-node distance / predecessor / visited state, then streams the src-to-dst node sequence out with a valid/ready handshake.
- Sits between the mission-level requester (start/src/dst) and the motion sequencer that consumes the path.

Parameters:
- NUM_NODES, 26, number of valid node ids (0..NUM_NODES-1).
- NODE_W, 5, node id width.
- DIST_W, 7, distance accumulator width; all-ones value = INF (127).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only in IDLE
- src  in  NODE_W  source node, sampled on accepted start
- dst  in  NODE_W  destination node, sampled on accepted start
- node_addr  out  NODE_W  address to adjacency ROM (registered)
- nb0, nb1, nb2, nb3  in  7 each  ROM neighbour entries; bits[6:5] = edge cost, bits[4:0] = neighbour id
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at search/stream completion
- err  out  1  valid with done; held until next accepted start
- path_len  out  NODE_W  number of nodes in path incl. src and dst; valid from first path_valid
- total_cost  out  DIST_W  path cost; valid from first path_valid
- path_node  out  NODE_W  streamed node id
- path_valid  out  1  path_node valid
- path_ready  in  1  consumer accepts beat when valid && ready
- path_last  out  1  marks dst beat

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; dist[] = INF, visited[] = 0, prev[] = 0.
- ROM is combinational: nb0..nb3 correspond to node_addr in the same cycle.
- A neighbour slot is an edge iff id < NUM_NODES; id >= NUM_NODES (sentinel 30) is ignored regardless of cost. Cost 0..3 is taken as-is.
- States:
  - IDLE: on start, clear err, latch src/dst. If src or dst >= NUM_NODES -> ERR. Else -> INIT.
  - INIT (1 cycle): dist[] = INF except dist[src] = 0; visited[] = 0.
  - SELECT: linear scan over idx 0..NUM_NODES-1, one per cycle (NUM_NODES cycles). Picks unvisited node with minimum dist < INF; strict compare, so the lowest index wins ties. No candidate -> ERR. Candidate u == dst -> BACKTRACK. Else mark u visited, node_addr = u -> EXPAND.
  - EXPAND (4 cycles, slot 0..3 in order): for a valid edge to unvisited v, with nd = dist[u] + cost computed at DIST_W bits: if nd < dist[v] (strict), set dist[v] = nd and prev[v] = u. -> SELECT.
  - BACKTRACK: push dst, then follow prev[] until src, pushing each node into an internal LIFO of depth NUM_NODES, one per cycle. Count pushes into path_len; total_cost = dist[dst]. A walk exceeding NUM_NODES pushes -> ERR (defensive). -> STREAM.
  - STREAM: pop LIFO, so src is emitted first. path_node/path_valid are registered. path_node, path_valid and path_last stay stable while path_valid && !path_ready. path_last = 1 on dst beat. After the last handshake: path_valid = 0, done pulse -> IDLE.
  - ERR (1 cycle): err = 1, done pulse, no path beats -> IDLE.
- src == dst: SELECT picks src first; path_len = 1, total_cost = 0, single beat with path_last = 1.
- start while busy: ignored. start in the same cycle done pulses: ignored; start is accepted only from IDLE on a later cycle.
- rst_n asserted mid-search or mid-stream: immediate return to reset state; a partial stream is abandoned and path_valid drops asynchronously.
- Worst-case latency before first beat: 1 + NUM_NODES × (NUM_NODES + 4) + NUM_NODES + 1 cycles.

Test Plan:
- src=0, dst=3, path_ready=1 -> beats 0,1,2,3; path_last on 3; path_len=4; total_cost=7; done pulse; err=0.
- src=4, dst=24 -> beats 4,6,16,23,24; total_cost=10. The cost-11 route via 5,9,15,22,23 must not be chosen.
- src=7, dst=7 -> single beat 7 with path_last=1; path_len=1; total_cost=0.
- src=26, dst=3 -> ERR within 2 cycles of start: done=1, err=1, no path_valid; busy returns to 0.
- Bench ROM model with node 22 slot 3 = {3,30}; src=0, dst=25 -> err=1 with done, no beats.
- src=0, dst=3 with path_ready toggling 1,0,0,1,… -> path_node held stable while stalled, no beat lost or duplicated. A second test applies rst_n=0 during the second beat -> all outputs 0; a subsequent start with src=0, dst=3 completes correctly.
